// File: rtl/apb_wait_slave.sv
// -----------------------------------------------------------------------------
// apb_wait_slave
//
// APB completer with a DEPTH-entry byte register file, programmable wait-state
// insertion and address-range error reporting. Every response (PREADY, PRDATA,
// PSLVERR) comes straight from a flop, so an upstream bridge never closes a
// combinational loop through this block.
//
// Configuration macro: APB_WAIT_SLAVE_WAIT_EN
//   defined   : wait-state counter and WAIT state are built; each transfer
//               holds PREADY low for WAIT_CYCLES access cycles.
//   undefined : no counter, no WAIT state; every transfer completes zero-wait
//               (IDLE -> DONE). WAIT_CYCLES is then only range-checked.
//
// Parameters
//   DEPTH       : number of byte locations, valid addresses 0..DEPTH-1 (2..256)
//   WAIT_CYCLES : access cycles with PREADY low before completion (0..15)
//
// Ports
//   PCLK     in   clock, rising edge
//   PRESETn  in   asynchronous active-low reset
//   PSEL     in   select
//   PENABLE  in   access-phase indicator
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   [7:0] byte address
//   PWDATA   in   [7:0] write data
//   PRDATA   out  [7:0] read data, non-zero only while PREADY=1
//   PREADY   out  transfer completion, high for exactly one cycle
//   PSLVERR  out  address-range error, valid only while PREADY=1
// -----------------------------------------------------------------------------
module apb_wait_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       PSEL,
  input  logic       PENABLE,
  input  logic       PWRITE,
  input  logic [7:0] PADDR,
  input  logic [7:0] PWDATA,
  output logic [7:0] PRDATA,
  output logic       PREADY,
  output logic       PSLVERR
);

  localparam int         AW      = $clog2(DEPTH);
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  // Elaboration-time parameter sanity checks.
  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("apb_wait_slave: WAIT_CYCLES must be in 0..15");
  end
  if (DEPTH < 2 || DEPTH > 256) begin : g_bad_depth
    $error("apb_wait_slave: DEPTH must be in 2..256");
  end

`ifdef APB_WAIT_SLAVE_WAIT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd2
  } state_t;
`endif

  state_t     r_state;
`ifdef APB_WAIT_SLAVE_WAIT_EN
  logic [3:0] r_cnt;
`endif
  logic [7:0] r_addr;
  logic       r_write;
  logic [7:0] r_wdata;
  logic       r_ready;
  logic [7:0] r_rdata;
  logic       r_slverr;

  logic [7:0] r_mem [DEPTH];

  logic       w_setup;
  logic [7:0] w_acc_addr;
  logic       w_acc_write;
  logic       w_acc_err;
  logic [7:0] w_acc_rdata;
  logic       w_mem_we;

  assign w_setup = PSEL && !PENABLE;

  // The response loaded on entry to DONE describes the access being entered.
  // From IDLE (zero-wait) the address is being latched at that very edge, so
  // it is taken from the bus; from WAIT it comes from the latch registers.
  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first) so no latch is inferred.
  always_comb begin
    w_acc_addr  = r_addr;
    w_acc_write = r_write;
    if (r_state == S_IDLE) begin
      w_acc_addr  = PADDR;
      w_acc_write = PWRITE;
    end
    w_acc_err   = ({1'b0, w_acc_addr} >= DEPTH_W);
    w_acc_rdata = 8'h00;
    if (!w_acc_write && !w_acc_err) begin
      w_acc_rdata = r_mem[w_acc_addr[AW-1:0]];
    end
  end

  // Commit only at a genuine closing edge of an in-range write; an abort
  // (PSEL low) or an errored address leaves the array untouched.
  assign w_mem_we = (r_state == S_DONE) && PSEL && PENABLE && r_write && !w_acc_err;

  // NOTE: state flops use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state  <= S_IDLE;
`ifdef APB_WAIT_SLAVE_WAIT_EN
      r_cnt    <= 4'd0;
`endif
      r_addr   <= 8'h00;
      r_write  <= 1'b0;
      r_wdata  <= 8'h00;
      r_ready  <= 1'b0;
      r_rdata  <= 8'h00;
      r_slverr <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready  <= 1'b0;
          r_rdata  <= 8'h00;
          r_slverr <= 1'b0;
          if (w_setup) begin
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
`ifdef APB_WAIT_SLAVE_WAIT_EN
            if (WAIT_CYCLES == 0) begin
              r_state  <= S_DONE;
              r_ready  <= 1'b1;
              r_rdata  <= w_acc_rdata;
              r_slverr <= w_acc_err;
            end else begin
              r_cnt   <= 4'(WAIT_CYCLES);
              r_state <= S_WAIT;
            end
`else
            r_state  <= S_DONE;
            r_ready  <= 1'b1;
            r_rdata  <= w_acc_rdata;
            r_slverr <= w_acc_err;
`endif
          end
        end

`ifdef APB_WAIT_SLAVE_WAIT_EN
        S_WAIT: begin
          if (!PSEL) begin
            // Abort: bridge dropped the select mid-transfer.
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
          end else if (!PENABLE) begin
            // Fresh setup while waiting: drop the old access, start over.
            r_addr  <= PADDR;
            r_write <= PWRITE;
            r_wdata <= PWDATA;
            r_cnt   <= 4'(WAIT_CYCLES);
          end else if (r_cnt == 4'd1) begin
            r_state  <= S_DONE;
            r_cnt    <= 4'd0;
            r_ready  <= 1'b1;
            r_rdata  <= w_acc_rdata;
            r_slverr <= w_acc_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
`endif

        S_DONE: begin
          // One-cycle completion; abort or not, the next state is IDLE.
          r_state  <= S_IDLE;
          r_ready  <= 1'b0;
          r_rdata  <= 8'h00;
          r_slverr <= 1'b0;
        end

        default: begin
          r_state  <= S_IDLE;
          r_ready  <= 1'b0;
          r_rdata  <= 8'h00;
          r_slverr <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the register file has no reset; its contents are undefined at
  // power-up and survive PRESETn, which also lets it map onto plain RAM.
  always_ff @(posedge PCLK) begin
    if (w_mem_we) begin
      r_mem[r_addr[AW-1:0]] <= r_wdata;
    end
  end

  assign PREADY  = r_ready;
  assign PRDATA  = r_rdata;
  assign PSLVERR = r_slverr;

endmodule
